divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 101 ++++++++++
 tb/tb_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle restoring unsigned divider: accepts A/B when ready, returns Q/R/dbz WIDTH cycles later.
// One restoring step per clock; single operation in flight, new operands are ignored while busy.
module divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             i_valid,
  output logic             ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             last_step;

  // The quotient bits shift into the low end of the dividend register as it empties.
  always_comb begin
    shifted   = {rem, dvd[WIDTH-1]};
    trial     = shifted - (WIDTH + 2)'(dsr);
    qbit      = ~trial[WIDTH+1];
    rem_next  = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
    dvd_next  = {dvd[WIDTH-2:0], qbit};
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_valid) next_state = CALC;
      CALC:    if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      o_valid <= 1'b0;
      Q       <= '0;
      R       <= '0;
      dbz     <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      cnt     <= '0;
    end else begin
      state   <= next_state;
      ready   <= (next_state == IDLE);
      o_valid <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (i_valid) begin
            dvd <= A;
            dsr <= B;
            rem <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= dvd_next;
          cnt <= cnt + CW'(1);
          // Divide by zero falls out naturally as Q = all ones, R = A.
          if (last_step) begin
            Q   <= dvd_next;
            R   <= rem_next[WIDTH-1:0];
            dbz <= (dsr == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboarded bench for divider (WIDTH=4): directed cases, back-to-back issue, reset abort, exhaustive sweep.
module tb_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         i_valid;
  logic         ready;
  logic         o_valid;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         dbz;

  divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .i_valid(i_valid),
    .ready(ready), .o_valid(o_valid), .Q(Q), .R(R), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;
  bit   cont   = 1'b0;
  bit   cont_have_last = 1'b0;
  int   cont_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Accept monitor: computes the expected result from the operands seen at the accept edge.
  always @(posedge clk) begin
    exp_t e;
    int   a, b;
    cyc = cyc + 1;
    if (rst_n && i_valid && ready) begin
      a = int'(A);
      b = int'(B);
      if (b == 0) begin
        e.q = {W{1'b1}};
        e.r = A;
        e.d = 1'b1;
      end else begin
        e.q = W'(a / b);
        e.r = W'(a % b);
        e.d = 1'b0;
      end
      e.cyc = cyc;
      sb.push_back(e);
      if (cont) begin
        if (cont_have_last) chk("b2b_spacing", cyc - cont_last, W + 2);
        cont_have_last = 1'b1;
        cont_last = cyc;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      if (sb.size() == 0) begin
        chk("extra_o_valid", 32'(o_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("Q", 32'(Q), 32'(e.q));
        chk("R", 32'(R), 32'(e.r));
        chk("dbz", 32'(dbz), 32'(e.d));
        chk("latency", cyc - e.cyc, W);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
    A = a;
    B = b;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    A = '0;
    B = '0;
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);

    // First accept on the first edge after reset release; track ready through the operation.
    rst_n = 1'b1;
    issue(4'd13, 4'd3);
    chk("busy_ready_0", 32'(ready), 32'd0);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'(ready), 32'd0);
      chk("o_valid_timing", 32'(o_valid), (i == W) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("ready_back", 32'(ready), 32'd1);
    chk("o_valid_pulse", 32'(o_valid), 32'd0);
    drain();

    issue(4'd15, 4'd0);
    drain();
    issue(4'd15, 4'd1);
    drain();
    repeat (3) @(negedge clk);
    chk("hold_Q", 32'(Q), 32'd15);
    issue(4'd7, 4'd9);
    chk("keep_Q_on_accept", 32'(Q), 32'd15);
    chk("keep_R_on_accept", 32'(R), 32'd0);
    drain();
    issue(4'd0, 4'd5);
    drain();

    // i_valid held high with operands changing every cycle.
    cont_have_last = 1'b0;
    cont = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
    cont = 1'b0;
    drain();

    // Reset two cycles into an operation aborts it without a result.
    issue(4'd14, 4'd4);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_o_valid", 32'(o_valid), 32'd0);
    chk("abort_Q", 32'(Q), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(4'd14, 4'd4);
    drain();
    chk("retry_Q", 32'(Q), 32'd3);
    chk("retry_R", 32'(R), 32'd2);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(W'(a), W'(b));
      end
    end
    drain();
    repeat (W + 4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
